lab2_proc_imm_encoder: RTL and testbench

Pipelined immediate encoder: accepts a 32-bit instruction template, an immediate type and a 32-bit immediate value, and returns the template with the immediate scattered into the RISC-V bit fields of that type. It is the inverse of the datapath immediate generator and serves the trap/patch unit and the self-check harness that re-encodes decoded immediates. It uses val/rdy handshakes on both sides, a two-stage pipeline with full back-pressure, range/alignment checking, and a saturating error counter.

---
 rtl/lab2_proc_imm_pkg.sv | 14 +
 rtl/lab2_proc_imm_encoder_if.sv | 24 ++
 rtl/lab2_proc_imm_field_insert.sv | 40 ++++
 rtl/lab2_proc_imm_encoder.sv | 115 +++++++++++
 tb/tb_lab2_proc_imm_encoder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lab2_proc_imm_pkg.sv
// rtl/lab2_proc_imm_pkg.sv - immediate type encodings shared by encoder and generator
package lab2_proc_imm_pkg;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    function automatic logic imm_type_legal(input logic [2:0] imm_type);
        return imm_type <= IMM_J;
    endfunction

endpackage

// File: rtl/lab2_proc_imm_encoder_if.sv
// rtl/lab2_proc_imm_encoder_if.sv - request/response val/rdy bundle for the immediate encoder
interface lab2_proc_imm_encoder_if;

    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_imm_type;
    logic [31:0] req_imm;
    logic [31:0] req_inst;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_val, req_imm_type, req_imm, req_inst, resp_rdy,
        input  req_rdy, resp_val, resp_inst, resp_err
    );

    modport slave (
        input  req_val, req_imm_type, req_imm, req_inst, resp_rdy,
        output req_rdy, resp_val, resp_inst, resp_err
    );

endinterface

// File: rtl/lab2_proc_imm_field_insert.sv
// rtl/lab2_proc_imm_field_insert.sv - scatters an immediate into the RISC-V fields of its type
import lab2_proc_imm_pkg::*;

module lab2_proc_imm_field_insert (
    input  logic [2:0]  imm_type,
    input  logic [31:0] imm,
    input  logic [31:0] inst,
    output logic [31:0] inst_out
);

    // No format carries imm[31:21]; they only matter to the range check upstream.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];

    always_comb begin
        inst_out = inst;
        case (imm_type)
            IMM_I: inst_out[31:20] = imm[11:0];
            IMM_S: begin
                inst_out[31:25] = imm[11:5];
                inst_out[11:7]  = imm[4:0];
            end
            IMM_B: begin
                inst_out[31]    = imm[12];
                inst_out[7]     = imm[11];
                inst_out[30:25] = imm[10:5];
                inst_out[11:8]  = imm[4:1];
            end
            IMM_U: inst_out[31:12] = imm[19:0];
            IMM_J: begin
                inst_out[31]    = imm[20];
                inst_out[19:12] = imm[19:12];
                inst_out[20]    = imm[11];
                inst_out[30:21] = imm[10:1];
            end
            default: inst_out = inst;
        endcase
    end

endmodule

// File: rtl/lab2_proc_imm_encoder.sv
// rtl/lab2_proc_imm_encoder.sv - two-stage immediate encoder; LAB2_PROC_IMM_ENC_RANGE_CHECK_EN enables range/alignment errors
import lab2_proc_imm_pkg::*;

module lab2_proc_imm_encoder (
    input  logic                        clk,
    input  logic                        reset,
    lab2_proc_imm_encoder_if.slave      bus,
    output logic [15:0]                 err_count
);

    logic        s1_val_q,  s1_val_d;
    logic [2:0]  s1_type_q, s1_type_d;
    logic [31:0] s1_imm_q,  s1_imm_d;
    logic [31:0] s1_inst_q, s1_inst_d;
    logic        s1_err_q,  s1_err_d;
    logic        s2_val_q,  s2_val_d;
    logic [31:0] s2_inst_q, s2_inst_d;
    logic        s2_err_q,  s2_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        s1_rdy;
    logic        s2_rdy;
    logic        req_err;
    logic [31:0] ins_inst;

    assign s2_rdy = !s2_val_q || bus.resp_rdy;
    assign s1_rdy = !s1_val_q || s2_rdy;

    assign bus.req_rdy   = s1_rdy;
    assign bus.resp_val  = s2_val_q;
    assign bus.resp_inst = s2_inst_q;
    assign bus.resp_err  = s2_err_q;
    assign err_count     = err_cnt_q;

    always_comb begin
        req_err = 1'b0;
`ifdef LAB2_PROC_IMM_ENC_RANGE_CHECK_EN
        case (bus.req_imm_type)
            IMM_I, IMM_S: req_err = !(&bus.req_imm[31:11] || ~|bus.req_imm[31:11]);
            IMM_B:        req_err = bus.req_imm[0] || !(&bus.req_imm[31:12] || ~|bus.req_imm[31:12]);
            IMM_J:        req_err = bus.req_imm[0] || !(&bus.req_imm[31:20] || ~|bus.req_imm[31:20]);
            IMM_U:        req_err = |bus.req_imm[31:20];
            default:      req_err = 1'b1;
        endcase
`else
        req_err = !imm_type_legal(bus.req_imm_type);
`endif
    end

    lab2_proc_imm_field_insert u_insert (
        .imm_type (s1_type_q),
        .imm      (s1_imm_q),
        .inst     (s1_inst_q),
        .inst_out (ins_inst)
    );

    always_comb begin
        s1_val_d  = s1_val_q;
        s1_type_d = s1_type_q;
        s1_imm_d  = s1_imm_q;
        s1_inst_d = s1_inst_q;
        s1_err_d  = s1_err_q;
        s2_val_d  = s2_val_q;
        s2_inst_d = s2_inst_q;
        s2_err_d  = s2_err_q;
        err_cnt_d = err_cnt_q;

        if (s1_rdy) begin
            s1_val_d = bus.req_val;
            if (bus.req_val) begin
                s1_type_d = bus.req_imm_type;
                s1_imm_d  = bus.req_imm;
                s1_inst_d = bus.req_inst;
                s1_err_d  = req_err;
            end
        end

        // Erroring requests leave the template untouched.
        if (s2_rdy) begin
            s2_val_d = s1_val_q;
            if (s1_val_q) begin
                s2_inst_d = s1_err_q ? s1_inst_q : ins_inst;
                s2_err_d  = s1_err_q;
            end
        end

        if (s2_val_q && bus.resp_rdy && s2_err_q && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_val_q  <= 1'b0;
            s1_type_q <= 3'd0;
            s1_imm_q  <= 32'd0;
            s1_inst_q <= 32'd0;
            s1_err_q  <= 1'b0;
            s2_val_q  <= 1'b0;
            s2_inst_q <= 32'd0;
            s2_err_q  <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            s1_val_q  <= s1_val_d;
            s1_type_q <= s1_type_d;
            s1_imm_q  <= s1_imm_d;
            s1_inst_q <= s1_inst_d;
            s1_err_q  <= s1_err_d;
            s2_val_q  <= s2_val_d;
            s2_inst_q <= s2_inst_d;
            s2_err_q  <= s2_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_lab2_proc_imm_encoder.sv
// tb/tb_lab2_proc_imm_encoder.sv - randomized scoreboard bench for lab2_proc_imm_encoder
module tb_lab2_proc_imm_encoder;

    typedef struct {
        logic [2:0]  t;
        logic [31:0] imm;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] err_count;

    lab2_proc_imm_encoder_if bus ();

    lab2_proc_imm_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cnt_m    = 0;
    int          resp_count = 0;
    logic        last_req_fire, last_resp_fire, last_resp_err;
    logic [31:0] last_resp_inst;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_inst;
    logic        prev_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] inst);
        exp_t        e;
        longint      v;
        logic        ok;
        logic [31:0] r;
        v = longint'($signed(imm));
        r = inst;
        ok = 1'b0;
        case (t)
            3'd0: begin
                r  = (inst & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
                ok = (v >= -2048) && (v <= 2047);
            end
            3'd1: begin
                r  = (inst & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                ok = (v >= -2048) && (v <= 2047);
            end
            3'd2: begin
                r  = (inst & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 11) & 32'h1) << 7)
                   | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8);
                ok = (v >= -4096) && (v <= 4095) && ((v % 2) == 0);
            end
            3'd3: begin
                r  = (inst & 32'h0000_0FFF) | ((imm & 32'hF_FFFF) << 12);
                ok = imm < 32'h0010_0000;
            end
            3'd4: begin
                r  = (inst & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 12) & 32'hFF) << 12)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21);
                ok = (v >= -1048576) && (v <= 1048575) && ((v % 2) == 0);
            end
            default: ok = 1'b0;
        endcase
`ifndef LAB2_PROC_IMM_ENC_RANGE_CHECK_EN
        if (t <= 3'd4) ok = 1'b1;
`endif
        e.t = t;
        e.imm = imm;
        e.err = !ok;
        e.inst = ok ? r : inst;
        return e;
    endfunction

`ifdef LAB2_PROC_IMM_ENC_RANGE_CHECK_EN
    function automatic logic [31:0] gen(input logic [2:0] t, input logic [31:0] i);
        case (t)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {12'd0, i[31:12]};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction
`endif

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
            default: return 32'($urandom_range(0, 32'h1F_FFFF));
        endcase
    endfunction

    task automatic step(input logic v, input logic [2:0] t, input logic [31:0] im,
                        input logic [31:0] in_, input logic rr);
        exp_t e;
        @(negedge clk);
        bus.req_val      = v;
        bus.req_imm_type = t;
        bus.req_imm      = im;
        bus.req_inst     = in_;
        bus.resp_rdy     = rr;
        #1;
        check("req_rdy", 32'(bus.req_rdy), 32'(!(q.size() == 2 && !rr)));
        check("err_count", 32'(err_count), 32'(cnt_m));
        if (stall_prev) begin
            check("hold_val", 32'(bus.resp_val), 32'd1);
            check("hold_inst", bus.resp_inst, prev_inst);
            check("hold_err", 32'(bus.resp_err), 32'(prev_err));
        end
        last_resp_fire = bus.resp_val && rr;
        if (last_resp_fire) begin
            last_resp_inst = bus.resp_inst;
            last_resp_err  = bus.resp_err;
            resp_count++;
            if (q.size() == 0) begin
                check("spurious_resp", 32'(bus.resp_val), 32'd0);
            end else begin
                e = q.pop_front();
                check("resp_inst", bus.resp_inst, e.inst);
                check("resp_err", 32'(bus.resp_err), 32'(e.err));
`ifdef LAB2_PROC_IMM_ENC_RANGE_CHECK_EN
                if (!e.err) check("round_trip", gen(e.t, bus.resp_inst), e.imm);
`endif
                if (e.err && cnt_m < 65535) cnt_m++;
            end
        end
        last_req_fire = v && bus.req_rdy;
        stall_prev = bus.resp_val && !rr;
        prev_inst  = bus.resp_inst;
        prev_err   = bus.resp_err;
        @(posedge clk);
        if (last_req_fire) q.push_back(model(t, im, in_));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_resp_val", 32'(bus.resp_val), 32'd0);
        check("rst_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("rst_err_count", 32'(err_count), 32'd0);
        q.delete();
        cnt_m = 0;
        stall_prev = 1'b0;
        bus.req_val = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_single(input string tag, input logic [2:0] t, input logic [31:0] im,
                               input logic [31:0] in_, input logic [31:0] exp_inst, input logic exp_err);
        int lat;
        lat = 0;
        step(1'b1, t, im, in_, 1'b1);
        check({tag, "_accept"}, 32'(last_req_fire), 32'd1);
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
            if (last_resp_fire) lat = i;
        end
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_inst"}, last_resp_inst, exp_inst);
        check({tag, "_err"}, 32'(last_resp_err), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] s_imm[6];
        int          sent, base, saw_full;

        reset = 1'b1;
        bus.req_val = 1'b0;
        bus.req_imm_type = 3'd0;
        bus.req_imm = 32'd0;
        bus.req_inst = 32'd0;
        bus.resp_rdy = 1'b0;
        #1;
        check("init_resp_val", 32'(bus.resp_val), 32'd0);
        check("init_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("init_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        send_single("i_rt", 3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
`ifdef LAB2_PROC_IMM_ENC_RANGE_CHECK_EN
        send_single("b_mis", 3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0063, 1'b1);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("b_mis_count", 32'(err_count), 32'd1);
        send_single("j_max", 3'd4, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0);
        send_single("j_ovf", 3'd4, 32'h0010_0000, 32'h0000_006F, 32'h0000_006F, 1'b1);
        send_single("u_ovf", 3'd3, 32'h0010_0000, 32'h0000_0037, 32'h0000_0037, 1'b1);
`else
        send_single("b_mis", 3'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("b_mis_count", 32'(err_count), 32'd0);
        send_single("j_max", 3'd4, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0);
        send_single("j_ovf", 3'd4, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b0);
        send_single("u_ovf", 3'd3, 32'h0010_0000, 32'h0000_0037, 32'h0000_0037, 1'b0);
`endif
        send_single("ill6", 3'd6, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678, 1'b1);

        // Back-pressure with resp_rdy cycling 1,0,0,1.
        for (int i = 0; i < 6; i++) s_imm[i] = 32'($urandom_range(0, 4095)) - 32'd2048;
        sent = 0;
        saw_full = 0;
        base = resp_count;
        for (int k = 0; k < 60 && (resp_count - base) < 6; k++) begin
            if (sent < 6)
                step(1'b1, 3'd1, s_imm[sent], 32'h0000_2023 + 32'(sent), (k % 4 == 0) || (k % 4 == 3));
            else
                step(1'b0, 3'd1, 32'd0, 32'd0, (k % 4 == 0) || (k % 4 == 3));
            if (last_req_fire) sent++;
            else if (sent < 6) saw_full = 1;
        end
        check("bp_responses", 32'(resp_count - base), 32'd6);
        check("bp_full_seen", 32'(saw_full), 32'd1);

        // Reset with two requests stalled in flight.
        step(1'b1, 3'd0, 32'd5, 32'h0000_0013, 1'b0);
        step(1'b1, 3'd6, 32'd5, 32'h0000_0013, 1'b0);
        check("two_inflight", 32'(q.size()), 32'd2);
        do_reset();
        send_single("post_rst", 3'd0, 32'h0000_07FF, 32'h0000_0093, 32'h7FF0_0093, 1'b0);

        // Randomized traffic against the scoreboard.
        for (int k = 0; k < 400; k++)
            step(($urandom % 4) != 0, 3'($urandom_range(0, 7)), rand_imm(), $urandom, ($urandom % 3) != 0);
        for (int k = 0; k < 4; k++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("drained", 32'(q.size()), 32'd0);

        // Drive the counter into saturation with illegal-type requests.
        for (int k = 0; k < 65540; k++) step(1'b1, 3'd7, 32'd0, 32'hCAFE_0000, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        check("sat_count", 32'(err_count), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
